tiger_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the execute-stage ALU.
- It is the requester side of the pipeline stall protocol. It raises stallRqEx whenever the instruction in execute needs HI/LO, or the unit itself, while an operation is in flight.
- It obeys stallEx from the stall logic so an instruction held in execute is never issued twice.

---
 rtl/tiger_defines.sv | 42 ++++
 rtl/tiger_divider_core.sv | 94 +++++++++
 rtl/tiger_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_tiger_muldiv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_defines.sv
// -----------------------------------------------------------------------------
// tiger_defines
// Shared definitions for the multiply/divide unit:
//   - MD_* opcode encodings as seen on opEx
//   - ST_* FSM state encodings
//   - DIV_ITER (restoring iterations) and DIV_CYCLES (iterations + sign fix)
//   - md_flags_t: per-operation attributes captured when an op is accepted
//   - abs32(): magnitude helper; 0x80000000 maps to itself and is then
//     treated as the unsigned value 2^31
// -----------------------------------------------------------------------------
package tiger_defines;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam int DIV_ITER   = 32;
  localparam int DIV_CYCLES = DIV_ITER + 1;

  typedef struct packed {
    logic is_signed;  // MULT or DIV
    logic a_neg;      // signed op with negative dividend / multiplicand
    logic q_neg;      // signed op whose operand signs differ
    logic div_zero;   // divisor was zero
    logic early;      // divide resolved without iterating
  } md_flags_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/tiger_divider_core.sv
// -----------------------------------------------------------------------------
// tiger_divider_core
// Iterative restoring 32-bit unsigned divider, one quotient bit per cycle.
// A start_i pulse loads the operands; DIV_ITER cycles later done_o is high
// for the cycle in which the final iteration is committed, and the results
// are held on quotient_o/remainder_o from the following cycle onward.
// A zero divisor naturally yields quotient 0xFFFFFFFF, remainder = dividend.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start_i          load operands and begin iterating
//   dividend_i[31:0] unsigned dividend
//   divisor_i[31:0]  unsigned divisor
//   done_o           last iteration is being committed this cycle
//   quotient_o[31:0] quotient
//   remainder_o[31:0] remainder
// -----------------------------------------------------------------------------
module tiger_divider_core
  import tiger_defines::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        run_q, run_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;

  // Shifted partial remainder and trial subtraction are 33 bits wide: bit 32
  // of the trial is the borrow that decides the quotient bit.
  logic [32:0] rem_shift;
  logic [32:0] trial;

  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  assign done_o      = run_q && (cnt_q == 6'(DIV_ITER - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  always_comb begin
    // NOTE: every signal is given its hold value first so no path through
    // this block leaves a variable unassigned, which would infer a latch.
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (run_q) begin
      // Dividend bits shift out of quo_q as quotient bits shift in.
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/tiger_muldiv.sv
// -----------------------------------------------------------------------------
// tiger_muldiv
// Multi-cycle multiply/divide unit with architectural HI/LO registers, placed
// beside the execute-stage ALU. It requests a pipeline stall while an op is
// in flight and a muldiv-class instruction is waiting in execute, and it only
// accepts an op on an edge where stallEx is low, so a held instruction is
// issued exactly once.
//   MULT/MULTU : busy MUL_CYCLES cycles, {hi,lo} = 64-bit product
//   DIV/DIVU   : busy DIV_CYCLES cycles (32 iterations + sign fix),
//                lo = quotient (truncated toward zero), hi = remainder
//                (sign of dividend); x/0 -> lo=0xFFFFFFFF, hi=x
//   MTHI/MTLO  : write rsVal, single cycle
//   MFHI/MFLO  : hiLoRead combinational
// Optional build macro TIGER_MULDIV_EARLY_OUT_EN: divides with a zero divisor
// or |dividend| < |divisor| finish after 1 busy cycle; results unchanged.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   opValidEx           muldiv-class instruction in execute
//   opEx[2:0]           operation (MD_* encodings)
//   rsVal, rtVal[31:0]  forwarded operands
//   stallEx             execute stage stalled this cycle
//   stallRqEx           stall request (busy && opValidEx)
//   busy                operation in flight
//   hi, lo[31:0]        architectural HI/LO
//   hiLoRead[31:0]      HI for MFHI, LO for MFLO, else 0
// -----------------------------------------------------------------------------
module tiger_muldiv
  import tiger_defines::*;
#(
  parameter int MUL_CYCLES = 4  // 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        opValidEx,
  input  logic [2:0]  opEx,
  input  logic [31:0] rsVal,
  input  logic [31:0] rtVal,
  input  logic        stallEx,
  output logic        stallRqEx,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hiLoRead
);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  md_flags_t   flags_q, flags_d;

  logic        accept;
  logic        is_div_op;
  logic        is_signed_op;
  logic        early_hit;
  logic        core_start;
  logic        core_done;
  logic [31:0] mag_a, mag_b;
  logic [31:0] core_quo, core_rem;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] mul_a_ext, mul_b_ext, product;

  assign busy      = (state_q != ST_IDLE);
  // Derived from busy and opValidEx only; stallEx must never feed back here.
  assign stallRqEx = busy & opValidEx;
  // The !busy term is redundant with the stall protocol but keeps a held op
  // from ever being taken twice.
  assign accept    = opValidEx & ~stallEx & ~busy;

  assign is_div_op    = (opEx == MD_DIV) || (opEx == MD_DIVU);
  assign is_signed_op = (opEx == MD_MULT) || (opEx == MD_DIV);
  assign mag_a        = abs32(rsVal, is_signed_op);
  assign mag_b        = abs32(rtVal, is_signed_op);

`ifdef TIGER_MULDIV_EARLY_OUT_EN
  assign early_hit = (rtVal == 32'd0) || (mag_a < mag_b);
`else
  assign early_hit = 1'b0;
`endif

  assign core_start = accept & is_div_op & ~early_hit;

  tiger_divider_core u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (core_start),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .done_o      (core_done),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

  // Operands are held stable for the whole MUL state, so the product is a
  // multicycle path of MUL_CYCLES cycles. Truncating a 64x64 product of the
  // sign- or zero-extended operands gives the correct 64-bit result.
  assign mul_a_ext = {{32{flags_q.is_signed & op_a_q[31]}}, op_a_q};
  assign mul_b_ext = {{32{flags_q.is_signed & op_b_q[31]}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // Sign fix applied in ST_FIX to the unsigned core results.
  always_comb begin
    quo_fix = flags_q.q_neg ? (~core_quo + 32'd1) : core_quo;
    rem_fix = flags_q.a_neg ? (~core_rem + 32'd1) : core_rem;
    if (flags_q.div_zero) quo_fix = '1;
    if (flags_q.early) begin
      // Core never ran: quotient is 0 and the remainder is the dividend.
      quo_fix = flags_q.div_zero ? '1 : '0;
      rem_fix = op_a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d           = rsVal;
          op_b_d           = rtVal;
          flags_d.is_signed = is_signed_op;
          flags_d.a_neg    = is_signed_op & rsVal[31];
          flags_d.q_neg    = is_signed_op & (rsVal[31] ^ rtVal[31]);
          flags_d.div_zero = (rtVal == 32'd0);
          flags_d.early    = early_hit;
          case (opEx)
            MD_MULT, MD_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = '0;
            end
            MD_DIV, MD_DIVU: state_d = early_hit ? ST_FIX : ST_DIV;
            MD_MTHI:         hi_d    = rsVal;
            MD_MTLO:         lo_d    = rsVal;
            default:         ;  // MFHI/MFLO: read only
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == 6'(MUL_CYCLES - 1)) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        if (core_done) state_d = ST_FIX;
      end
      default: begin  // ST_FIX
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      flags_q <= flags_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    case (opEx)
      MD_MFHI: hiLoRead = hi_q;
      MD_MFLO: hiLoRead = lo_q;
      default: hiLoRead = '0;
    endcase
  end

endmodule

// File: tb/tb_tiger_muldiv.sv
// -----------------------------------------------------------------------------
// tb_tiger_muldiv
// Self-checking bench for tiger_muldiv. A driver issues ops and pushes the
// expected outcome (from an arithmetic reference model) into a queue; a
// monitor observes accepts on the interface, pops, and compares hi/lo,
// hiLoRead, busy and stallRqEx cycle by cycle. The stall logic is modelled
// as stallEx = stallRqEx | d_stall, where d_stall is an external hazard.
// -----------------------------------------------------------------------------
module tb_tiger_muldiv;
  import tiger_defines::*;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid_ex = 1'b0;
  logic [2:0]  op_ex = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        d_stall = 1'b0;
  logic        stall_ex;
  logic        stall_rq_ex;
  logic        busy;
  logic [31:0] hi, lo, hi_lo_read;

  assign stall_ex = stall_rq_ex | d_stall;

  always #5 clk = ~clk;

  tiger_muldiv #(.MUL_CYCLES(MUL_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opValidEx (op_valid_ex),
    .opEx      (op_ex),
    .rsVal     (rs_val),
    .rtVal     (rt_val),
    .stallEx   (stall_ex),
    .stallRqEx (stall_rq_ex),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .hiLoRead  (hi_lo_read)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: architectural effect of one op from plain arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint          p;
    longint unsigned pu;
    longint          ma, mb;
    int              sa, sb;
    e.op = op; e.lat = 0; e.rd = '0;
    e.hi = hi_m; e.lo = lo_m;
    sa = a; sb = b;
    case (op)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = MUL_LAT;
      end
      MD_MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = MUL_LAT;
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else if (op == MD_DIV) begin
          e.lo = sa / sb; e.hi = sa % sb;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
        e.lat = 33;
`ifdef TIGER_MULDIV_EARLY_OUT_EN
        if (op == MD_DIV) begin
          ma = (sa < 0) ? -longint'(sa) : longint'(sa);
          mb = (sb < 0) ? -longint'(sb) : longint'(sb);
        end else begin
          ma = longint'({32'd0, a});
          mb = longint'({32'd0, b});
        end
        if (b == 32'd0 || ma < mb) e.lat = 1;
`else
        ma = 0; mb = 0;
`endif
      end
      MD_MTHI: e.hi = a;
      MD_MTLO: e.lo = a;
      MD_MFHI: e.rd = hi_m;
      default: e.rd = lo_m;
    endcase
    hi_m = e.hi; lo_m = e.lo;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int   rem_cycles = 0;
  bit   res_pend = 1'b0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rem_cycles = 0;
        res_pend   = 1'b0;
        exp_q.delete();
        continue;
      end
      if (res_pend) begin
        check("hi", hi, cur.hi);
        check("lo", lo, cur.lo);
        res_pend = 1'b0;
      end
      check("busy", 32'(busy), 32'(rem_cycles > 0));
      check("stall_rq", 32'(stall_rq_ex), 32'((rem_cycles > 0) && op_valid_ex));
      if (rem_cycles > 0) begin
        rem_cycles--;
        if (rem_cycles == 0) res_pend = 1'b1;
      end
      if (op_valid_ex && !stall_ex) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 32'(exp_q.size()), 32'd1);
        end else begin
          cur = exp_q.pop_front();
          if (cur.op == MD_MFHI || cur.op == MD_MFLO) check("hilo_read", hi_lo_read, cur.rd);
          else if (cur.op == MD_MTHI || cur.op == MD_MTLO) res_pend = 1'b1;
          else rem_cycles = cur.lat;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output int stalls);
    int n;
    exp_q.push_back(model(op, a, b));
    op_valid_ex = 1'b1; op_ex = op; rs_val = a; rt_val = b;
    d_stall = (hold > 0);
    stalls = 0;
    repeat (hold) begin @(posedge clk); #1; end
    d_stall = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (stall_rq_ex) stalls++;
      if (!stall_ex) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    op_valid_ex = 1'b0;
    op_ex  = 3'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int st;
    int w;
    logic [2:0] rop;
    // Reset state, with an op presented while reset is held.
    op_valid_ex = 1'b1; op_ex = MD_MULT;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall_rq", 32'(stall_rq_ex), 32'd0);
    op_valid_ex = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // MULT followed one idle cycle later by MFLO: MFLO waits 3 cycles.
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, st);
    @(posedge clk); #1;
    issue(MD_MFLO, 32'd0, 32'd0, 0, st);
    check("mflo_stall_cycles", 32'(st), 32'd3);

    // Divides, including the boundary cases.
    issue(MD_DIVU, 32'd100, 32'd7, 0, st);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, st);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, st);
    issue(MD_DIVU, 32'd5, 32'd0, 0, st);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0, 0, st);
    issue(MD_DIVU, 32'd3, 32'd9, 0, st);
    issue(MD_MFHI, 32'd0, 32'd0, 0, st);

    // MULT held by an external stall for 3 cycles: exactly one issue.
    issue(MD_MULT, 32'h1234_5678, 32'hFEDC_BA98, 3, st);
    issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 0, st);
    issue(MD_MFLO, 32'd0, 32'd0, 0, st);

    // Reset pulsed during a divide aborts it immediately.
    issue(MD_DIV, 32'd1000, 32'd3, 0, st);
    repeat (9) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(MD_MTHI, 32'h0000_1234, 32'd0, 0, st);
    issue(MD_MFHI, 32'd0, 32'd0, 0, st);

    // Randomised traffic with idle gaps and external stalls.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      issue(rop, pick_operand(), pick_operand(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Drain the last result.
    w = 0;
    while ((exp_q.size() != 0 || rem_cycles != 0 || res_pend) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) check("drain_timeout", 32'(w), 32'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
